// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the parametrised clearable RAM.
//   state_t       clear-sequencer state encoding (ST_CLEAR, ST_READY)
//   RD_FIRST      read-during-write mode: Dout returns the old word
//   WR_FIRST_M    read-during-write mode: Dout returns the merged new word
//   clog2()       ceiling log2, used to size the clear pointer
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam bit RD_FIRST   = 1'b0;
  localparam bit WR_FIRST_M = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// ram_clear_seq: walks a pointer over every implemented word while in
// ST_CLEAR, then parks in ST_READY until a clear request arrives.
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (enters ST_CLEAR, pointer 0)
//   clr      synchronous request to restart the clear walk from word 0
//   state    current sequencer state (also serves as the debug view)
//   clr_ptr  word being cleared this cycle while state == ST_CLEAR
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int PTR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output state_t           state,
  output logic [PTR_W-1:0] clr_ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr) begin
            clr_ptr <= '0;
          end else if (clr_ptr == LAST) begin
            // The last word is written on this same edge, so READY is
            // entered exactly DEPTH cycles after the walk started.
            state   <= ST_READY;
            clr_ptr <= '0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        ST_READY: begin
          if (clr) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
          end
        end
        default: begin
          state   <= ST_CLEAR;
          clr_ptr <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ram_module_param_clr.sv
// ram_module_param_clr: parametrised single-port synchronous RAM with
// per-byte write enables, selectable read-during-write behaviour and a
// built-in clear sequencer.
//   CLK    rising-edge clock
//   RST    asynchronous reset, active-low
//   EN     access enable; WE selects write, BE selects bytes
//   Addr   word address; Addr >= DEPTH is out of range (ERR pulse)
//   Din    write data
//   CLR    request to re-clear the whole array to CLEAR_VAL
//   Dout   registered read data
//   VALID  Dout was updated by an accepted access on the last edge
//   BUSY   clear walk in progress; accesses are ignored
//   ERR    one-cycle pulse for an accepted out-of-range access
// Access protocol: there is no back-pressure. An access is accepted on
// any edge where EN=1, BUSY=0 and CLR=0; its result appears on Dout with
// VALID=1 in the following cycle. VALID is never asserted otherwise.
module ram_module_param_clr
  import ram_pkg::*;
#(
  parameter int               DATA_W    = 8,
  parameter int               ADDR_W    = 8,
  parameter int               DEPTH     = 256,
  parameter bit               WR_FIRST  = RD_FIRST,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                WE,
  input  logic [DATA_W/8-1:0] BE,
  input  logic [ADDR_W-1:0]   Addr,
  input  logic [DATA_W-1:0]   Din,
  input  logic                CLR,
  output logic [DATA_W-1:0]   Dout,
  output logic                VALID,
  output logic                BUSY,
  output logic                ERR
);

  localparam int NB    = DATA_W / 8;
  localparam int PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  // Range check at full address width plus one bit so DEPTH == 2**ADDR_W
  // is representable and nothing wraps.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  state_t           seq_state;
  logic [PTR_W-1:0] clr_ptr;
  logic             busy;
  logic             accept;
  logic             in_range;
  logic [PTR_W-1:0] user_idx;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged;
  logic [PTR_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [NB-1:0]    wr_be;

  logic [DATA_W-1:0] mem [DEPTH];

  ram_clear_seq #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_clear_seq (
    .clk     (CLK),
    .rst_n   (RST),
    .clr     (CLR),
    .state   (seq_state),
    .clr_ptr (clr_ptr)
  );

  assign busy     = (seq_state == ST_CLEAR);
  assign BUSY     = busy;
  // CLR in a READY cycle takes priority and drops the access.
  assign accept   = EN && !busy && !CLR;
  assign in_range = ({1'b0, Addr} < DEPTH_X);
  assign user_idx = Addr[PTR_W-1:0];

  // Single write port shared between the clear walk and user writes.
  always_comb begin
    old_word = mem[user_idx];
    merged   = old_word;
    for (int i = 0; i < NB; i++) begin
      if (WE && BE[i]) merged[8*i +: 8] = Din[8*i +: 8];
    end
    wr_idx  = user_idx;
    wr_data = merged;
    wr_be   = '0;
    if (busy) begin
      wr_idx  = clr_ptr;
      wr_data = CLEAR_VAL;
      wr_be   = '1;
    end else if (accept && in_range && WE) begin
      wr_be = BE;
    end
  end

  // Array storage has no reset; the clear walk initialises it.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Dout  <= '0;
      VALID <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      VALID <= 1'b0;
      ERR   <= 1'b0;
      if (accept) begin
        VALID <= 1'b1;
        if (!in_range) begin
          ERR  <= 1'b1;
          Dout <= CLEAR_VAL;
        end else if (WR_FIRST == WR_FIRST_M) begin
          Dout <= merged;
        end else begin
          Dout <= old_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_module_param_clr.sv
// Bench for ram_module_param_clr. Two instances share one stimulus stream:
//   dut_a: 8-bit, DEPTH 256, read-first, CLEAR_VAL 8'h00
//   dut_b: 16-bit, DEPTH 200, write-first, CLEAR_VAL 16'h5A3C
// A behavioural model (word arrays plus a remaining-clear-cycles counter)
// predicts every output of both instances.
module tb_ram_module_param_clr;

  localparam logic [15:0] CV_B = 16'h5A3C;

  logic        clk;
  logic        rst_n;
  logic        en, we, clr;
  logic [1:0]  be;
  logic [7:0]  addr;
  logic [15:0] din;

  logic [7:0]  a_dout;
  logic        a_valid, a_busy, a_err;
  logic [15:0] b_dout;
  logic        b_valid, b_busy, b_err;

  int checks;
  int fails;

  // model
  logic [7:0]  mem_a [256];
  logic [15:0] mem_b [200];
  int          left_a, left_b;
  logic [7:0]  ma_dout;
  logic        ma_valid, ma_err;
  logic [15:0] mb_dout;
  logic        mb_valid, mb_err;

  ram_module_param_clr #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(256), .WR_FIRST(1'b0), .CLEAR_VAL(8'h00)
  ) dut_a (
    .CLK(clk), .RST(rst_n), .EN(en), .WE(we), .BE(be[0:0]), .Addr(addr),
    .Din(din[7:0]), .CLR(clr), .Dout(a_dout), .VALID(a_valid),
    .BUSY(a_busy), .ERR(a_err)
  );

  ram_module_param_clr #(
    .DATA_W(16), .ADDR_W(8), .DEPTH(200), .WR_FIRST(1'b1), .CLEAR_VAL(CV_B)
  ) dut_b (
    .CLK(clk), .RST(rst_n), .EN(en), .WE(we), .BE(be), .Addr(addr),
    .Din(din), .CLR(clr), .Dout(b_dout), .VALID(b_valid),
    .BUSY(b_busy), .ERR(b_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    left_a = 256; left_b = 200;
    ma_dout = '0; ma_valid = 0; ma_err = 0;
    mb_dout = '0; mb_valid = 0; mb_err = 0;
  endtask

  task automatic model_update();
    logic [15:0] nw;
    // instance A
    if (left_a > 0) begin
      ma_valid = 0; ma_err = 0;
      if (clr) left_a = 256;
      else begin
        left_a--;
        if (left_a == 0) for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
      end
    end else if (clr) begin
      left_a = 256; ma_valid = 0; ma_err = 0;
    end else if (en) begin
      ma_valid = 1; ma_err = 0;
      ma_dout = mem_a[addr];
      if (we && be[0]) mem_a[addr] = din[7:0];
    end else begin
      ma_valid = 0; ma_err = 0;
    end
    // instance B
    if (left_b > 0) begin
      mb_valid = 0; mb_err = 0;
      if (clr) left_b = 200;
      else begin
        left_b--;
        if (left_b == 0) for (int i = 0; i < 200; i++) mem_b[i] = CV_B;
      end
    end else if (clr) begin
      left_b = 200; mb_valid = 0; mb_err = 0;
    end else if (en) begin
      mb_valid = 1;
      if (addr >= 200) begin
        mb_err = 1; mb_dout = CV_B;
      end else begin
        mb_err = 0;
        nw = mem_b[addr];
        if (we && be[0]) nw[7:0]  = din[7:0];
        if (we && be[1]) nw[15:8] = din[15:8];
        mem_b[addr] = nw;
        mb_dout = nw;
      end
    end else begin
      mb_valid = 0; mb_err = 0;
    end
  endtask

  // driver: called at a negedge, returns at the next negedge
  task automatic step(input logic en_i, input logic we_i, input logic [1:0] be_i,
                      input logic [7:0] addr_i, input logic [15:0] din_i,
                      input logic clr_i);
    en = en_i; we = we_i; be = be_i; addr = addr_i; din = din_i; clr = clr_i;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'b00, 8'h00, 16'h0000, 1'b0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int cnt_a, cnt_b;
    en = 0; we = 0; be = 0; addr = 0; din = 0; clr = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({a_dout, a_valid, a_err, a_busy} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL reset_a: got %h/%b%b%b expected 00/001", a_dout, a_valid, a_err, a_busy);
    end
    checks++;
    if ({b_dout, b_valid, b_err, b_busy} !== {16'h0000, 1'b0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL reset_b: got %h/%b%b%b expected 0000/001", b_dout, b_valid, b_err, b_busy);
    end
    rst_n = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 400; k++) begin
      if (a_busy) cnt_a++;
      if (b_busy) cnt_b++;
      if (!a_busy && !b_busy) break;
      idle();
    end
    checks++;
    if (cnt_a != 256) begin fails++; $display("FAIL busy_len_a: got %0d expected 256", cnt_a); end
    checks++;
    if (cnt_b != 200) begin fails++; $display("FAIL busy_len_b: got %0d expected 200", cnt_b); end
  endtask

  task automatic test_clear_read();
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b0, 2'b00, 8'(i), 16'h0000, 1'b0);
      checks++;
      if ({a_dout, a_valid, a_err} !== {8'h00, 1'b1, 1'b0}) begin
        fails++; $display("FAIL clear_read_a[%0d]: got %h/%b%b expected 00/10", i, a_dout, a_valid, a_err);
      end
      checks++;
      if ({b_dout, b_valid, b_err} !== {CV_B, 1'b1, (i >= 200) ? 1'b1 : 1'b0}) begin
        fails++; $display("FAIL clear_read_b[%0d]: got %h/%b%b expected %h/1%b", i, b_dout, b_valid, b_err, CV_B, i >= 200);
      end
    end
  endtask

  task automatic test_en_toggle();
    logic e;
    for (int i = 1; i <= 10; i++) begin
      e = (i % 2 == 1);
      step(e, 1'b1, 2'b11, 8'(i - 1), 16'(i), 1'b0);
      checks++;
      if ({a_valid, b_valid} !== {e, e}) begin
        fails++; $display("FAIL en_valid[%0d]: got %b%b expected %b%b", i, a_valid, b_valid, e, e);
      end
    end
    for (int a = 0; a < 10; a++) begin
      step(1'b1, 1'b0, 2'b00, 8'(a), 16'h0000, 1'b0);
      checks++;
      if (a_dout !== ((a % 2 == 0) ? 8'(a + 1) : 8'h00)) begin
        fails++; $display("FAIL en_readback_a[%0d]: got %h", a, a_dout);
      end
      checks++;
      if (b_dout !== ((a % 2 == 0) ? 16'(a + 1) : CV_B)) begin
        fails++; $display("FAIL en_readback_b[%0d]: got %h", a, b_dout);
      end
    end
  endtask

  task automatic test_byte_enable();
    step(1'b1, 1'b1, 2'b11, 8'd3, 16'hA5A5, 1'b0);
    step(1'b1, 1'b1, 2'b01, 8'd3, 16'h1234, 1'b0);
    step(1'b1, 1'b0, 2'b00, 8'd3, 16'h0000, 1'b0);
    checks++;
    if (b_dout !== 16'hA534) begin fails++; $display("FAIL byte_en_b: got %h expected a534", b_dout); end
    checks++;
    if (a_dout !== 8'h34) begin fails++; $display("FAIL byte_en_a: got %h expected 34", a_dout); end
    // BE=0 write behaves as a read and changes nothing
    step(1'b1, 1'b1, 2'b00, 8'd3, 16'hFFFF, 1'b0);
    checks++;
    if ({b_dout, b_valid} !== {16'hA534, 1'b1}) begin
      fails++; $display("FAIL byte_en_zero_b: got %h/%b expected a534/1", b_dout, b_valid);
    end
  endtask

  task automatic test_collision();
    step(1'b1, 1'b1, 2'b11, 8'd5, 16'h0011, 1'b0);
    step(1'b1, 1'b1, 2'b11, 8'd5, 16'h0022, 1'b0);
    checks++;
    if (a_dout !== 8'h11) begin fails++; $display("FAIL collision_rd_first: got %h expected 11", a_dout); end
    checks++;
    if (b_dout !== 16'h0022) begin fails++; $display("FAIL collision_wr_first: got %h expected 0022", b_dout); end
  endtask

  task automatic test_out_of_range();
    step(1'b1, 1'b1, 2'b11, 8'd210, 16'h00FF, 1'b0);
    checks++;
    if ({b_dout, b_valid, b_err} !== {CV_B, 1'b1, 1'b1}) begin
      fails++; $display("FAIL oor_b: got %h/%b%b expected %h/11", b_dout, b_valid, b_err, CV_B);
    end
    checks++;
    if ({a_dout, a_err} !== {8'h00, 1'b0}) begin
      fails++; $display("FAIL oor_a: got %h/%b expected 00/0", a_dout, a_err);
    end
    idle();
    checks++;
    if ({b_err, b_valid} !== 2'b00) begin fails++; $display("FAIL oor_pulse: got err=%b valid=%b expected 0 0", b_err, b_valid); end
    step(1'b1, 1'b0, 2'b00, 8'd10, 16'h0000, 1'b0);
    checks++;
    if (b_dout !== CV_B) begin fails++; $display("FAIL oor_alias10: got %h expected %h", b_dout, CV_B); end
    step(1'b1, 1'b0, 2'b00, 8'd82, 16'h0000, 1'b0);
    checks++;
    if (b_dout !== CV_B) begin fails++; $display("FAIL oor_alias82: got %h expected %h", b_dout, CV_B); end
    step(1'b1, 1'b0, 2'b00, 8'd210, 16'h0000, 1'b0);
    checks++;
    if (a_dout !== 8'hFF) begin fails++; $display("FAIL oor_a_write: got %h expected ff", a_dout); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
           16'($urandom), 1'($urandom_range(0, 299) == 0));
      checks++;
      if ({a_dout, a_valid, a_err, a_busy} !== {ma_dout, ma_valid, ma_err, (left_a != 0)}) begin
        fails++; $display("FAIL random_a[%0d]: got %h/%b%b%b expected %h/%b%b%b", n,
                          a_dout, a_valid, a_err, a_busy, ma_dout, ma_valid, ma_err, left_a != 0);
      end
      checks++;
      if ({b_dout, b_valid, b_err, b_busy} !== {mb_dout, mb_valid, mb_err, (left_b != 0)}) begin
        fails++; $display("FAIL random_b[%0d]: got %h/%b%b%b expected %h/%b%b%b", n,
                          b_dout, b_valid, b_err, b_busy, mb_dout, mb_valid, mb_err, left_b != 0);
      end
    end
  endtask

  task automatic test_clr_and_reset();
    int cnt_a, cnt_b;
    for (int k = 0; k < 300 && (a_busy || b_busy); k++) idle();
    step(1'b1, 1'b1, 2'b11, 8'd7, 16'h7777, 1'b0);
    // CLR together with a read: CLR wins
    step(1'b1, 1'b0, 2'b00, 8'd7, 16'h0000, 1'b1);
    checks++;
    if ({a_valid, b_valid, a_busy, b_busy} !== 4'b0011) begin
      fails++; $display("FAIL clr_wins: got valid=%b%b busy=%b%b expected 00 11", a_valid, b_valid, a_busy, b_busy);
    end
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 400; k++) begin
      if (a_busy) cnt_a++;
      if (b_busy) cnt_b++;
      if (!a_busy && !b_busy) break;
      idle();
    end
    checks++;
    if (cnt_a != 256) begin fails++; $display("FAIL clr_busy_len_a: got %0d expected 256", cnt_a); end
    checks++;
    if (cnt_b != 200) begin fails++; $display("FAIL clr_busy_len_b: got %0d expected 200", cnt_b); end
    step(1'b1, 1'b0, 2'b00, 8'd7, 16'h0000, 1'b0);
    checks++;
    if ({a_dout, b_dout} !== {8'h00, CV_B}) begin
      fails++; $display("FAIL clr_data: got %h %h expected 00 %h", a_dout, b_dout, CV_B);
    end
    // reset at cycle 50 of a clear
    step(1'b0, 1'b0, 2'b00, 8'd0, 16'h0000, 1'b1);
    repeat (49) idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({a_dout, a_valid, a_busy, b_dout, b_valid, b_busy} !== {8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1}) begin
      fails++; $display("FAIL mid_clear_reset: got %h/%b%b %h/%b%b", a_dout, a_valid, a_busy, b_dout, b_valid, b_busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 400; k++) begin
      if (a_busy) cnt_a++;
      if (b_busy) cnt_b++;
      if (!a_busy && !b_busy) break;
      idle();
    end
    checks++;
    if (cnt_a != 256) begin fails++; $display("FAIL rst_busy_len_a: got %0d expected 256", cnt_a); end
    checks++;
    if (cnt_b != 200) begin fails++; $display("FAIL rst_busy_len_b: got %0d expected 200", cnt_b); end
    step(1'b1, 1'b0, 2'b00, 8'd199, 16'h0000, 1'b0);
    checks++;
    if ({a_dout, b_dout, b_err} !== {8'h00, CV_B, 1'b0}) begin
      fails++; $display("FAIL rst_data: got %h %h/%b expected 00 %h/0", a_dout, b_dout, b_err, CV_B);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    @(negedge clk);
    test_reset();
    test_clear_read();
    test_en_toggle();
    test_byte_enable();
    test_collision();
    test_out_of_range();
    test_random();
    test_clr_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
